// File: rtl/table_fsm_pkg.sv
// Shared types, default tables and helper functions for the table-driven Moore FSM.
package table_fsm_pkg;

  typedef enum logic {MODE_STEP = 1'b0, MODE_RUN = 1'b1} mode_t;

  // Entry {state,in} lives at bits [idx*3 +: 3]; in=0 walks 2,5,1,4,6,7,3,0 and in=1 holds.
  localparam logic [47:0] DEF_NEXT_3x1 = {
    3'd7, 3'd3, 3'd6, 3'd7, 3'd5, 3'd1, 3'd4, 3'd6,
    3'd3, 3'd0, 3'd2, 3'd5, 3'd1, 3'd4, 3'd0, 3'd2
  };

  localparam logic [15:0] DEF_OUT_3x2 = {
    2'd1, 2'd1, 2'd0, 2'd3, 2'd0, 2'd3, 2'd3, 2'd0
  };

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pushbutton followed by a rising-edge detector.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/table_fsm.sv
// Parametrised table-driven Moore FSM with synchronised manual stepping,
// auto-run prescaler, state-change counter and halt detection.
module table_fsm
  import table_fsm_pkg::*;
#(
  parameter int SW = 3,
  parameter int IW = 1,
  parameter int OW = 2,
  parameter int CW = 16,
  parameter int DIV = 100,
  parameter logic [SW-1:0] RESET_STATE = 3'd2,
  parameter logic [(2**(SW+IW))*SW-1:0] NEXT_TABLE = DEF_NEXT_3x1,
  parameter logic [(2**SW)*OW-1:0] OUT_TABLE = DEF_OUT_3x2
) (
  input  logic          hz100,
  input  logic          reset,
  input  logic          step_btn,
  input  logic [IW-1:0] in,
  input  logic          run_mode,
  input  logic          sync_clr,
  output logic [SW-1:0] state,
  output logic [SW-1:0] next_state,
  output logic [OW-1:0] out,
  output logic [CW-1:0] step_count,
  output logic          halted
);

  localparam int PW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam int NENT = 2 ** (SW + IW);
  localparam int NST = 2 ** SW;

  if (SW < 1 || SW > 6 || IW < 1 || IW > 4 || OW < 1 || CW < 1 || DIV < 2) begin : g_param_error
    $error("table_fsm: parameter out of range");
  end

  logic          step_rise;
  logic [IW-1:0] in_meta;
  logic [IW-1:0] in_s;
  logic [PW-1:0] prescaler;
  logic [PW-1:0] prescaler_nxt;
  logic [SW-1:0] state_nxt;
  logic [CW-1:0] count_nxt;
  logic          adv;
  mode_t         mode;

  logic [SW-1:0] next_lut [NENT];
  logic [OW-1:0] out_lut  [NST];

  // Unpack the flat parameter vectors so lookups index an array directly.
  for (genvar i = 0; i < NENT; i++) begin : g_next_lut
    assign next_lut[i] = NEXT_TABLE[i*SW +: SW];
  end
  for (genvar i = 0; i < NST; i++) begin : g_out_lut
    assign out_lut[i] = OUT_TABLE[i*OW +: OW];
  end

  sync_edge u_step_sync (
    .clk  (hz100),
    .rst_n(reset),
    .d    (step_btn),
    .rise (step_rise)
  );

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      in_meta <= '0;
      in_s    <= '0;
    end else begin
      in_meta <= in;
      in_s    <= in_meta;
    end
  end

  assign mode       = mode_t'(run_mode);
  assign next_state = next_lut[{state, in_s}];
  assign out        = out_lut[state];
  assign halted     = (next_state == state);

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state      <= RESET_STATE;
      step_count <= '0;
      prescaler  <= '0;
    end else begin
      state      <= state_nxt;
      step_count <= count_nxt;
      prescaler  <= prescaler_nxt;
    end
  end

  // Clear outranks an advance; the prescaler only runs in auto mode so each entry waits a full period.
  always_comb begin
    state_nxt     = state;
    count_nxt     = step_count;
    prescaler_nxt = '0;
    adv           = 1'b0;
    if (mode == MODE_RUN) begin
      adv           = (prescaler == PW'(DIV - 1));
      prescaler_nxt = adv ? '0 : prescaler + PW'(1);
    end else begin
      adv = step_rise;
    end
    if (sync_clr) begin
      state_nxt     = RESET_STATE;
      count_nxt     = '0;
      prescaler_nxt = '0;
    end else if (adv) begin
      state_nxt = next_state;
      if (!halted) begin
        count_nxt = step_count + CW'(1);
      end
    end
  end

endmodule

// File: doc/table_fsm.md
Name: table_fsm

Overview:
- Parametrised, table-driven Moore state machine for the lab FPGA top level.
- Generalises the fixed 3-bit decoder/mux FSM in three ways:
  - state width, input width and output width are parameters;
  - next-state and output tables are parameter vectors;
  - it runs on the system clock, with a synchronised step button, an auto-run prescaler, a step counter and halt detection.
- Drives LED/seven-segment debug outputs from the top module.

Parameters:
- SW, 3: state width in bits (1..6).
- IW, 1: external input width in bits (1..4).
- OW, 2: output width in bits.
- CW, 16: step counter width.
- DIV, 100: auto-run period in clock cycles (>=2); one step per second at hz100.
- RESET_STATE, 3'd2: state loaded on reset or clear.
- NEXT_TABLE, see Behaviour: packed, 2^(SW+IW)*SW bits. Entry at index {state,in} sits at bits [idx*SW +: SW].
- OUT_TABLE, see Behaviour: packed, 2^SW*OW bits. Entry for a state sits at bits [state*OW +: OW].

Ports:
- hz100  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- step_btn  input  1  raw manual step pushbutton, asynchronous
- in  input  IW  raw FSM inputs, asynchronous
- run_mode  input  1  0 = manual step, 1 = auto-run
- sync_clr  input  1  synchronous clear
- state  output  SW  current state
- next_state  output  SW  combinational next state
- out  output  OW  Moore output
- step_count  output  CW  count of state changes
- halted  output  1  next_state == state

Behaviour:
- Reset (reset=0, asynchronous):
  - state = RESET_STATE; step_count = 0; prescaler = 0.
  - Both synchroniser stages and the step edge register = 0.
  - Outputs settle from state: out = OUT_TABLE[RESET_STATE]; next_state and halted from the table.
- Synchronisers:
  - step_btn and in each pass through 2 flops, giving step_s and in_s.
  - The step edge register holds the previous step_s; rise = step_s & ~prev.
  - Step latency is 3 cycles from a step_btn rising edge to the state update.
- next_state = NEXT_TABLE[{state, in_s}], combinational.
- out = OUT_TABLE[state], combinational (Moore). No latency relative to state.
- halted = (next_state == state), combinational.
- Advance event (adv):
  - run_mode=0: adv = rise.
  - run_mode=1: adv when prescaler == DIV-1. The prescaler increments each cycle and wraps to 0 on adv.
  - The prescaler is held at 0 while run_mode=0, so entering auto mode gives its first adv DIV cycles later.
  - In auto mode, rise is ignored.
- On adv:
  - state <= next_state.
  - step_count increments by 1 only if next_state != state.
  - step_count wraps from 2^CW-1 to 0.
- sync_clr=1 has priority over adv in the same cycle:
  - state <= RESET_STATE; step_count <= 0; prescaler <= 0.
  - Synchronisers keep running.
- Reset asserted mid-operation overrides everything immediately. The first adv after release needs a fresh step edge or a full DIV period.
- Table defaults:
  - in_s[0]=0: cycle 2→5→1→4→6→7→3→0→2.
  - in_s[0]=1: hold current state.
  - OUT_TABLE by state 0..7: 0,3,3,0,3,0,1,1.
- Table vectors are not checked at elaboration. Out-of-range widths are a parameter error (assertion in simulation).

Decomposition:
- Package table_fsm_pkg:
  - function clog2 for the prescaler width;
  - default table localparams DEF_NEXT_3x1 and DEF_OUT_3x2;
  - typedef mode_t {MODE_STEP=0, MODE_RUN=1}.
- One sub-module: sync_edge (2-flop synchroniser plus rising-edge detect). Instantiated once for step_btn; the in bus uses only its synchroniser.

Test Plan:
- Reset with defaults, in=0: hold reset=0 then release → state=2, out=3, next_state=5, halted=0, step_count=0.
- Manual mode, in=0, eight step_btn pulses, each separated by ≥4 cycles:
  - states 5,1,4,6,7,3,0,2;
  - outs 0,3,3,1,1,0,0,3;
  - step_count=8;
  - each update exactly 3 cycles after the button rise.
- in=1, three step pulses from state 2 → state stays 2, halted=1, step_count unchanged at 0.
- Auto mode, DIV=4: set run_mode=1 → state changes at cycles 4, 8, 12 after the switch. Step pulses during auto mode have no effect.
- sync_clr and adv in the same cycle from state 6 with step_count=5 → state=2, step_count=0, prescaler=0.
- CW=2: five state changes → step_count sequence 1,2,3,0,1. Separately, assert reset mid-prescale → outputs return to reset values asynchronously, before the next clock edge.
